// File: rtl/shift_unit_seq_pkg.sv
// rtl/shift_unit_seq_pkg.sv - mode codes and FSM state encoding for the multi-cycle shifter
package cpu_shift_pkg;

  localparam logic [2:0] SH_SHR  = 3'b000;
  localparam logic [2:0] SH_SHRA = 3'b001;
  localparam logic [2:0] SH_SHL  = 3'b010;
  localparam logic [2:0] SH_SHLA = 3'b011;
  localparam logic [2:0] SH_ROR  = 3'b100;
  localparam logic [2:0] SH_ROL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Codes 110/111 are not shifts; the unit passes the operand through for them.
  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= SH_ROL);
  endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// rtl/shift_unit_seq_if.sv - start/done request bus between control unit and shifter
interface shift_unit_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
);
  logic                  start;
  logic [2:0]            mode;
  logic [DATA_WIDTH-1:0] a_in;
  logic [AMT_WIDTH-1:0]  amt_in;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  ovf;

  modport master (
    output start, mode, a_in, amt_in,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, mode, a_in, amt_in,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/shift_unit_seq_shift_step.sv
// rtl/shift_unit_seq_shift_step.sv - combinational single-step shifter by k with shla overflow
module shift_step
  import cpu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 4,
  parameter int K_WIDTH    = $clog2(STEP) + 1
) (
  input  logic [2:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [K_WIDTH-1:0]    i_k,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ovf
);

  logic [31:0]           w_k;
  logic [31:0]           w_kc;
  logic [DATA_WIDTH-1:0] w_shl;
  logic [DATA_WIDTH-1:0] w_back;

  assign w_k   = 32'(i_k);
  assign w_kc  = 32'(DATA_WIDTH) - w_k;
  assign w_shl = i_data << w_k;
  // Overflow when shifting back arithmetically does not recover the input,
  // i.e. the top k+1 bits were not all equal.
  assign w_back = $signed(w_shl) >>> w_k;

  // Select the shifted value for the current mode; illegal modes pass through.
  always_comb begin
    o_data = i_data;
    o_ovf  = 1'b0;
    case (i_mode)
      SH_SHR:  o_data = i_data >> w_k;
      SH_SHRA: o_data = $signed(i_data) >>> w_k;
      SH_SHL:  o_data = w_shl;
      SH_SHLA: begin
        o_data = w_shl;
        o_ovf  = (w_back != i_data);
      end
      SH_ROR:  o_data = (i_data >> w_k) | (i_data << w_kc);
      SH_ROL:  o_data = (i_data << w_k) | (i_data >> w_kc);
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multi-cycle shift/rotate unit with start/done handshake
module shift_unit_seq
  import cpu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 4,
  parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input logic             clock,
  input logic             clear,
  shift_unit_seq_if.slave bus
);

  localparam int K_WIDTH = $clog2(STEP) + 1;

  state_t                r_state,   w_state_nxt;
  logic [DATA_WIDTH-1:0] r_work,    w_work_nxt;
  logic [DATA_WIDTH-1:0] r_result,  w_result_nxt;
  logic [2:0]            r_mode,    w_mode_nxt;
  logic [AMT_WIDTH-1:0]  r_rem,     w_rem_nxt;
  logic                  r_ovf_acc, w_ovf_acc_nxt;
  logic                  r_ovf,     w_ovf_nxt;

  logic [K_WIDTH-1:0]    w_k;
  logic [DATA_WIDTH-1:0] w_step_data;
  logic                  w_step_ovf;

  // A full STEP while enough distance remains, otherwise the remainder.
  assign w_k = (32'(r_rem) >= 32'(STEP)) ? K_WIDTH'(STEP) : K_WIDTH'(r_rem);

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP),
    .K_WIDTH    (K_WIDTH)
  ) u_step (
    .i_mode (r_mode),
    .i_data (r_work),
    .i_k    (w_k),
    .o_data (w_step_data),
    .o_ovf  (w_step_ovf)
  );

  // Next-state and datapath update; result/ovf only move on entry to DONE.
  always_comb begin
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_result_nxt  = r_result;
    w_mode_nxt    = r_mode;
    w_rem_nxt     = r_rem;
    w_ovf_acc_nxt = r_ovf_acc;
    w_ovf_nxt     = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_work_nxt    = bus.a_in;
          w_mode_nxt    = bus.mode;
          w_rem_nxt     = bus.amt_in;
          w_ovf_acc_nxt = 1'b0;
          if ((bus.amt_in != '0) && mode_legal(bus.mode)) begin
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt  = ST_DONE;
            w_result_nxt = bus.a_in;
            w_ovf_nxt    = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        w_work_nxt    = w_step_data;
        w_rem_nxt     = r_rem - AMT_WIDTH'(w_k);
        w_ovf_acc_nxt = r_ovf_acc | w_step_ovf;
        if (w_rem_nxt == '0) begin
          w_state_nxt  = ST_DONE;
          w_result_nxt = w_step_data;
          w_ovf_nxt    = r_ovf_acc | w_step_ovf;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; clear aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= ST_IDLE;
      r_work    <= '0;
      r_result  <= '0;
      r_mode    <= '0;
      r_rem     <= '0;
      r_ovf_acc <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_work    <= w_work_nxt;
      r_result  <= w_result_nxt;
      r_mode    <= w_mode_nxt;
      r_rem     <= w_rem_nxt;
      r_ovf_acc <= w_ovf_acc_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - scoreboard bench for the multi-cycle shift unit
module tb_shift_unit_seq;
  import cpu_shift_pkg::*;

  logic clk   = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  shift_unit_seq_if #(.DATA_WIDTH(32), .AMT_WIDTH(5)) bus();

  shift_unit_seq #(
    .DATA_WIDTH (32),
    .STEP       (4),
    .AMT_WIDTH  (5)
  ) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_miscmp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Bit-at-a-time reference model.
  task automatic model(input logic [2:0] m, input logic [31:0] a, input int amt,
                       output logic [31:0] r, output logic o);
    r = a;
    o = 1'b0;
    if (m <= 3'd5) begin
      for (int i = 0; i < amt; i++) begin
        case (m)
          3'd0:    r = {1'b0, r[31:1]};
          3'd1:    r = {r[31], r[31:1]};
          3'd4:    r = {r[0], r[31:1]};
          3'd5:    r = {r[30:0], r[31]};
          default: r = {r[30:0], 1'b0};
        endcase
      end
      if (m == 3'd3) begin
        for (int i = 0; i <= amt; i++) begin
          if (a[31-i] != a[31]) o = 1'b1;
        end
      end
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
        chk("latency", cyc - e.t0 + 1, e.lat);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
      end
    end
  end

  task automatic run_op(input logic [2:0] m, input logic [31:0] a, input logic [4:0] amt,
                        input int hold);
    exp_t e;
    int   ai;
    int   n;
    ai = int'(amt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.a_in   = a;
    bus.amt_in = amt;
    @(posedge clk);
    #1;
    model(m, a, ai, e.res, e.ovf);
    e.t0  = cyc;
    e.lat = (m > 3'd5 || ai == 0) ? 1 : (ai + 3) / 4 + 1;
    sb.push_back(e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.a_in   = ~a;
      bus.mode   = SH_ROL;
      bus.amt_in = amt ^ 5'h3;
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a_in   = '0;
    bus.amt_in = '0;
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mode   = '0;
    bus.a_in   = '0;
    bus.amt_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_ovf",    {31'd0, bus.ovf}, 32'd0);

    run_op(SH_SHLA, 32'hFF211111, 5'd11, 0);
    run_op(SH_SHRA, 32'h80000000, 5'd4,  0);
    run_op(SH_SHR,  32'h80000000, 5'd4,  0);
    run_op(SH_SHR,  32'hFFFFFFFF, 5'd31, 0);
    run_op(SH_ROR,  32'h00000001, 5'd1,  0);
    run_op(SH_ROL,  32'h80000001, 5'd4,  0);
    run_op(SH_SHLA, 32'h12345678, 5'd0,  0);
    run_op(3'b111,  32'h12345678, 5'd5,  0);
    run_op(SH_SHR,  32'hF0000000, 5'd12, 2);
    run_op(SH_SHLA, 32'h00000028, 5'd2,  0);
    repeat (3) @(negedge clk);
    chk("held_result", bus.result, 32'h000000A0);
    chk("held_ovf",    {31'd0, bus.ovf}, 32'd0);

    // Abort a long shl with clear; no done may follow.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = SH_SHL;
    bus.a_in   = 32'h0000FFFF;
    bus.amt_in = 5'd20;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_mid_shift", {31'd0, bus.busy}, 32'd1);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy",   {31'd0, bus.busy}, 32'd0);
    chk("clr_done",   {31'd0, bus.done}, 32'd0);
    chk("clr_result", bus.result, 32'd0);
    chk("clr_ovf",    {31'd0, bus.ovf}, 32'd0);
    repeat (8) @(negedge clk);

    run_op(SH_SHLA, 32'hC0000001, 5'd1, 0);
    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 0);
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Parametrised multi-cycle shift/rotate execution unit for the CPU datapath. It generalises the single-cycle shla ALU path to six shift/rotate modes, configurable data width and bits-per-cycle, and an arithmetic-overflow flag. The control unit starts it with a start/done handshake from the execute step. The result is then written into ZLow by the control sequencer.

Parameters:
DATA_WIDTH, 32, operand/result width in bits (power of two, >=8)
STEP, 4, maximum shift distance applied per cycle (power of two, 1..DATA_WIDTH)
AMT_WIDTH, $clog2(DATA_WIDTH), width of the shift-amount field

Ports:
clock  in  1  system clock, all state updates on rising edge
clear  in  1  synchronous active-high reset
start  in  1  request; sampled only while busy=0
mode  in  3  operation select, sampled with start
a_in  in  DATA_WIDTH  operand (from Y / source register)
amt_in  in  AMT_WIDTH  shift amount (low bits of second operand)
busy  out  1  high from the cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse, result/ovf valid
result  out  DATA_WIDTH  shifted value, held until next accepted start
ovf  out  1  shla overflow; 0 for all other modes; held with result

Behaviour:
- Reset: clock is the only clock. clear is synchronous and active-high. While clear=1 at a rising edge, the block enters IDLE and sets result=0, ovf=0, busy=0, done=0. clear overrides start. A clear during SHIFT aborts with no done pulse.
- Mode encoding: 000 shr (zero fill), 001 shra (sign fill), 010 shl, 011 shla (zero fill, overflow tracked), 100 ror, 101 rol. Codes 110/111 are illegal and execute as pass-through: result=a_in, ovf=0, amt ignored.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch a_in into the work register, latch mode, and set rem=amt_in. Go to SHIFT if rem!=0 and mode is legal; otherwise go to DONE.
- SHIFT: each cycle apply k=min(STEP,rem), set rem-=k, and update the work register. Go to DONE when the new rem==0.
- DONE: done=1 and busy=1 for exactly one cycle. result and ovf reflect the final work register. Next state is IDLE. A start in this cycle is ignored.
- Latency: done is high in the cycle beginning ceil(amt/STEP)+1 rising edges after the edge that sampled start. For amt=0 or an illegal mode this is 1 edge.
- start while busy=1 is ignored: no queueing and no effect on in-flight operands.
- Rotates take the amount modulo DATA_WIDTH, which amt_in already is by width.
- shla ovf is sticky across steps. It is set if any step shifts out a bit different from the sign bit of the pre-step value, or changes the sign bit. Equivalently, ovf=1 iff the top amt+1 bits of a_in are not all equal.
- result and ovf update only in the DONE-entry transition. They are stable between done pulses.

Decomposition:
- Package cpu_shift_pkg holds the mode localparams (SH_SHR, SH_SHRA, SH_SHL, SH_SHLA, SH_ROR, SH_ROL) and the state encoding for IDLE/SHIFT/DONE.
- Sub-module shift_step: purely combinational, a one-step shifter by k (0..STEP) with a per-step overflow output. It is instantiated once and reused each SHIFT cycle.

Test Plan:
- shla, a=0xFF211111, amt=11, STEP=4 -> done 4 edges after start, result=0x08888800, ovf=1.
- shra, a=0x80000000, amt=4 -> done after 2 edges, result=0xF8000000, ovf=0. Then shr with the same inputs -> result=0x08000000.
- shr, a=0xFFFFFFFF, amt=31 -> done after 9 edges, result=0x00000001. Then ror, a=0x00000001, amt=1 -> result=0x80000000. Then rol, a=0x80000001, amt=4 -> result=0x00000018.
- amt=0 with shla, a=0x12345678 -> done after 1 edge, result=0x12345678, ovf=0. Illegal mode 111, amt=5 -> same result, done after 1 edge.
- Assert start again while busy with a different a_in -> first result is unaffected and only one done pulse occurs. shla, a=0x00000028, amt=2 -> result=0x000000A0, ovf=0.
- clear asserted mid-SHIFT (shl amt=20) -> next cycle busy=0, result=0, no done pulse. A subsequent start is accepted normally.
